// File: rtl/reg_share_pkg.sv
// Shared constants and helpers for the register-sharing round-robin arbiter.
// onehot() is sized for the largest supported requester count; callers slice it.
package reg_share_pkg;

  localparam int N_DEF  = 4;
  localparam int W_DEF  = 8;
  localparam int CW_DEF = 8;
  localparam int MAX_N  = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin pick: the first set req bit at or above ptr wins,
// wrapping to the lowest set bit when nothing at or above ptr is requesting.
module rr_pick
  import reg_share_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] win,
  output logic           any
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic [IDW:0]   win_wide;
  logic           found;

  // Lower half holds only bits >= ptr and the upper half the full vector, so the
  // lowest set bit of the concatenation is the wrapped round-robin winner.
  always_comb begin
    mask     = '0;
    win_wide = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) mask[i] = (i >= int'(ptr));
    dbl = {req, req & mask};
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && dbl[i]) begin
        found    = 1'b1;
        win_wide = (IDW+1)'(i);
      end
    end
    any = |req;
    if (win_wide >= (IDW+1)'(N)) win = IDW'(win_wide - (IDW+1)'(N));
    else                         win = IDW'(win_wide);
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that shares one W-bit register between N requesters,
// loading the winner's data and returning a registered one-cycle grant pulse.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int W   = W_DEF,
  parameter int IDW = 2,
  parameter int CW  = CW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           upd,
  output logic [IDW-1:0] last_id,
  output logic [CW-1:0]  upd_cnt
);

  if (IDW != clog2(N)) begin : g_bad_idw
    $error("reg_share_arbiter: IDW must equal clog2(N)");
  end
  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("reg_share_arbiter: N must be in 2..8");
  end

  // Handshake: a requester holds req[i] and its wdata slice stable until it sees
  // gnt[i] high; a req still high during the grant cycle is a fresh request.

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [W-1:0]     shared_q, shared_d;
  logic             upd_q, upd_d;
  logic [IDW-1:0]   last_id_q, last_id_d;
  logic [CW-1:0]    upd_cnt_q, upd_cnt_d;

  logic [IDW-1:0]   win;
  logic             any;
  logic [MAX_N-1:0] win_oh;
  logic [W-1:0]     win_data;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  // Only the winner's slice is selected, so X on idle slices never reaches q.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == win) win_data = wdata[i*W +: W];
    end
  end

  always_comb begin
    win_oh    = onehot(32'(win));
    ptr_d     = ptr_q;
    gnt_d     = '0;
    shared_d  = shared_q;
    upd_d     = 1'b0;
    last_id_d = last_id_q;
    upd_cnt_d = upd_cnt_q;
    if (any) begin
      gnt_d     = win_oh[N-1:0];
      shared_d  = win_data;
      upd_d     = 1'b1;
      last_id_d = win;
      ptr_d     = (win == IDW'(N - 1)) ? '0 : win + IDW'(1);
      upd_cnt_d = upd_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      gnt_q     <= '0;
      shared_q  <= '0;
      upd_q     <= 1'b0;
      last_id_q <= '0;
      upd_cnt_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      shared_q  <= shared_d;
      upd_q     <= upd_d;
      last_id_q <= last_id_d;
      upd_cnt_q <= upd_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = shared_q;
  assign upd     = upd_q;
  assign last_id = last_id_q;
  assign upd_cnt = upd_cnt_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: reset, rotation, idle hold, wrap/skip,
// single requester with undriven slices, counter wrap and mid-stream reset.
module tb_reg_share_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;
  localparam int CW  = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           upd;
  logic [IDW-1:0] last_id;
  logic [CW-1:0]  upd_cnt;

  int errors;
  int checks;

  reg_share_arbiter #(
    .N   (N),
    .W   (W),
    .IDW (IDW),
    .CW  (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .upd     (upd),
    .last_id (last_id),
    .upd_cnt (upd_cnt)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
    chk("inv_upd", 32'(upd), 32'(|gnt));
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [7:0] e_q,
                         input logic e_upd, input logic [1:0] e_id, input logic [7:0] e_cnt);
    chk({tag, "_gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, "_q"}, 32'(q), 32'(e_q));
    chk({tag, "_upd"}, 32'(upd), 32'(e_upd));
    chk({tag, "_last_id"}, 32'(last_id), 32'(e_id));
    chk({tag, "_cnt"}, 32'(upd_cnt), 32'(e_cnt));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    req    = '0;
    wdata  = '0;

    // power-on reset
    #1 rst = 1'b1;
    #2 chk_all("por", 4'b0000, 8'h00, 1'b0, 2'd0, 8'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk_all("idle_after_por", 4'b0000, 8'h00, 1'b0, 2'd0, 8'd0);

    // asynchronous reset mid-cycle with all requesting
    req   = 4'b1111;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    step();
    chk_all("pre_rst0", 4'b0001, 8'h11, 1'b1, 2'd0, 8'd1);
    step();
    chk_all("pre_rst1", 4'b0010, 8'h22, 1'b1, 2'd1, 8'd2);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 4'b0000, 8'h00, 1'b0, 2'd0, 8'd0);
    step();
    chk_all("rst_held", 4'b0000, 8'h00, 1'b0, 2'd0, 8'd0);
    rst = 1'b0;

    // full-load rotation from ptr=0
    for (int k = 0; k < 8; k++) begin
      step();
      chk_all("rot", 4'(1 << (k % 4)), 8'(8'h11 * (k % 4 + 1)), 1'b1, 2'(k % 4), 8'(k + 1));
    end
    chk("rot_cnt8", 32'(upd_cnt), 32'd8);
    step();
    chk_all("rot_more0", 4'b0001, 8'h11, 1'b1, 2'd0, 8'd9);
    step();
    chk_all("rot_more1", 4'b0010, 8'h22, 1'b1, 2'd1, 8'd10);
    step();
    chk_all("rot_more2", 4'b0100, 8'h33, 1'b1, 2'd2, 8'd11);

    // idle hold
    req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_all("idle", 4'b0000, 8'h33, 1'b0, 2'd2, 8'd11);
    end

    // wrap and skip from ptr=3
    req = 4'b0011;
    step();
    chk_all("wrap0", 4'b0001, 8'h11, 1'b1, 2'd0, 8'd12);
    step();
    chk_all("wrap1", 4'b0010, 8'h22, 1'b1, 2'd1, 8'd13);
    step();
    chk_all("wrap2", 4'b0001, 8'h11, 1'b1, 2'd0, 8'd14);

    // single requester with undriven neighbour slices
    req   = 4'b0100;
    wdata = 'x;
    wdata[2*W +: W] = 8'hA5;
    step();
    chk_all("single0", 4'b0100, 8'hA5, 1'b1, 2'd2, 8'd15);
    wdata[2*W +: W] = 8'h5A;
    step();
    chk_all("single1", 4'b0100, 8'h5A, 1'b1, 2'd2, 8'd16);

    // counter wrap
    req   = 4'b0001;
    wdata = '0;
    for (int i = 0; i < 239; i++) begin
      wdata[W-1:0] = 8'(i);
      step();
    end
    chk_all("cnt255", 4'b0001, 8'(238), 1'b1, 2'd0, 8'd255);
    wdata[W-1:0] = 8'h9C;
    step();
    chk_all("cnt_wrap", 4'b0001, 8'h9C, 1'b1, 2'd0, 8'd0);
    req = 4'b0000;
    step();
    chk_all("cnt_wrap_hold", 4'b0000, 8'h9C, 1'b0, 2'd0, 8'd0);

    // reset mid-stream, ptr restarts at 0
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req   = 4'b1010;
    step();
    chk_all("ms_first", 4'b0010, 8'h22, 1'b1, 2'd1, 8'd1);
    #2 rst = 1'b1;
    #1 chk_all("ms_rst", 4'b0000, 8'h00, 1'b0, 2'd0, 8'd0);
    step();
    rst = 1'b0;
    step();
    chk_all("ms_post0", 4'b0010, 8'h22, 1'b1, 2'd1, 8'd1);
    step();
    chk_all("ms_post1", 4'b1000, 8'h44, 1'b1, 2'd3, 8'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin arbiter that shares one W-bit storage register between N requesters.
- Each cycle it picks at most one requesting client, loads that client's data into the shared register and returns a one-cycle grant pulse.
- Sits between requesting control blocks and the shared state register. Downstream logic reads q, upd and last_id.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, data width of the shared register.
- IDW, 2, width of the requester index; must equal ceil(log2(N)).
- CW, 8, width of the update counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request[i]: requester i wants to write.
- wdata  input  N*W  packed write data; slice i is bits [i*W +: W].
- gnt  output  N  one-hot grant pulse, registered.
- q  output  W  shared register contents.
- upd  output  1  high for one cycle when q was loaded on the last edge.
- last_id  output  IDW  index of the most recent winner.
- upd_cnt  output  CW  count of completed writes, wraps.

Behaviour:
- Reset (asynchronous, rst=1, takes effect immediately without waiting for clk):
  - gnt=0, q=0, upd=0, last_id=0, upd_cnt=0.
  - Internal pointer ptr=0.
  - All outputs hold these values while rst=1.
- Arbitration is combinational and evaluated every cycle. Search req starting at index ptr, ascending, wrapping from N-1 to 0. The first set bit wins (win).
- On each rising edge, if any req bit is set:
  - gnt <= onehot(win).
  - q <= wdata[win].
  - upd <= 1.
  - last_id <= win.
  - ptr <= (win+1) mod N.
  - upd_cnt <= upd_cnt+1, wrapping from 2^CW-1 to 0.
- On each rising edge, if req == 0:
  - gnt <= 0 and upd <= 0.
  - q, last_id, ptr and upd_cnt hold.
- Latency:
  - Request sampled at edge k; gnt, q and upd are valid after edge k.
  - gnt is a single-cycle pulse per win.
- Requester handshake:
  - Hold req and wdata stable until gnt[i] is seen high.
  - Deassert req in the gnt cycle unless another write is wanted.
  - A req still high in the gnt cycle is a new request.
- Fairness: with all N requesting continuously, grants rotate 0,1,..,N-1,0,... Any continuously-asserted requester is granted within N cycles.
- Single requester: it may win on consecutive cycles; ptr still advances to win+1.
- wdata of non-winning requesters is ignored.
- Reset mid-operation: gnt and upd drop at once. A pending winner is discarded and q clears. After release, arbitration restarts from ptr=0.
- The first edge after rst falls behaves as a normal edge.
- Invariants:
  - gnt is always one-hot or zero.
  - upd equals OR of gnt.
  - No X may propagate from unused wdata slices.

Decomposition:
- Shared package reg_share_pkg holds:
  - default constants N_DEF=4, W_DEF=8, CW_DEF=8.
  - a function onehot(idx) returning an N-bit vector.
  - a function clog2 used to check IDW.
- Sub-module rr_pick: purely combinational.
  - Inputs: req[N], ptr[IDW].
  - Outputs: win[IDW], any.
  - Implemented as a double-width masked priority encoder.
- The top level holds all registers (ptr, gnt, q, upd, last_id, upd_cnt), each in a single asynchronous-reset always block.

Test Plan:
- Reset: drive req=4'b1111 and rst=1 mid-cycle. Required: gnt=0, q=0, upd=0 and upd_cnt=0 immediately, before the next clk edge.
- Full load rotation: req=4'b1111, wdata slices 0x11/0x22/0x33/0x44, 8 edges. Required:
  - gnt sequence 0001,0010,0100,1000 repeated.
  - q sequence 11,22,33,44 repeated.
  - upd_cnt=8.
- Idle hold: after q=0x33, set req=0 for 5 edges. Required: gnt=0, upd=0, q=0x33, last_id=2 and upd_cnt unchanged.
- Wrap and skip: ptr=3 (last winner 2), req=4'b0011. Required: winner 0 (gnt=0001), then 1 (gnt=0010), then 0 again if req is held.
- Counter wrap: force 256 grants with CW=8. Required: upd_cnt returns to 0 and q holds the last written data.
- Reset mid-stream: req=4'b1010, assert rst for 1 cycle after the first grant, then release. Required: outputs cleared, and the first post-reset grant goes to requester 1 (ptr=0 search).
